// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: note codes, FSM states, entry layout.
package song_pkg;

    localparam int NOTE_W = 6;

    localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
    localparam logic [NOTE_W-1:0] NOTE_MAX  = 6'd36;
    localparam logic [NOTE_W-1:0] NOTE_END  = 6'h3F;

    localparam logic [NOTE_W-1:0] C1 = 6'd1,  CS1 = 6'd2,  D1 = 6'd3,  DS1 = 6'd4,
                                  E1 = 6'd5,  F1  = 6'd6,  FS1 = 6'd7, G1  = 6'd8,
                                  GS1 = 6'd9, A1  = 6'd10, AS1 = 6'd11, B1 = 6'd12;
    localparam logic [NOTE_W-1:0] C2 = 6'd13, CS2 = 6'd14, D2 = 6'd15, DS2 = 6'd16,
                                  E2 = 6'd17, F2  = 6'd18, FS2 = 6'd19, G2 = 6'd20,
                                  GS2 = 6'd21, A2 = 6'd22, AS2 = 6'd23, B2 = 6'd24;
    localparam logic [NOTE_W-1:0] C3 = 6'd25, CS3 = 6'd26, D3 = 6'd27, DS3 = 6'd28,
                                  E3 = 6'd29, F3  = 6'd30, FS3 = 6'd31, G3 = 6'd32,
                                  GS3 = 6'd33, A3 = 6'd34, AS3 = 6'd35, B3 = 6'd36;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_PAUSED,
        S_DONE
    } state_t;

    // Codes above the last playable note (other than the end marker) play as rests.
    function automatic logic [NOTE_W-1:0] playable(input logic [NOTE_W-1:0] note);
        return (note > NOTE_MAX) ? NOTE_REST : note;
    endfunction

endpackage

// File: rtl/song_tick_gen.sv
// Beat-tick divider: counts enabled cycles and emits a tick every tick_div cycles.
module song_tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] tick_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] terminal;

    // A divider of 0 behaves like 1; >= keeps a shrinking divider from stranding cnt.
    assign terminal = (tick_div == '0) ? '0 : tick_div - 1'b1;
    assign tick     = en && (cnt >= terminal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Steps through a synchronous note ROM and drives note_code with play/pause/stop control.
// Optional SONG_LOOP_EN: restart from entry 0 at end of song instead of halting in DONE.
module song_sequencer
    import song_pkg::*;
#(
    parameter int ROM_AW = 7,
    parameter int DUR_W  = 6,
    parameter int DIV_W  = 24
) (
    input  logic                    clk50,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    pause,
    input  logic                    stop,
    input  logic [DIV_W-1:0]        tick_div,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note_code,
    output logic                    busy,
    output logic                    song_done,
    output state_t                  fsm_state
);

    state_t            state;
    logic [DUR_W-1:0]  dur_cnt;
    logic [NOTE_W-1:0] cur_note;
    logic [NOTE_W-1:0] entry_note;
    logic [DUR_W-1:0]  entry_dur;
    logic              tick;
    logic              tick_en;
    logic              tick_clr;
    logic              last_beat;
    logic              song_end;

    assign entry_note = rom_data[DUR_W +: NOTE_W];
    assign entry_dur  = rom_data[DUR_W-1:0];

    // Pause and stop hold the counter, so a coincident terminal count is kept for resume.
    assign tick_en  = (state == S_PLAY) && !stop && !pause;
    assign tick_clr = stop || (state == S_LOAD);

    song_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk      (clk50),
        .reset    (reset),
        .en       (tick_en),
        .clr      (tick_clr),
        .tick_div (tick_div),
        .tick     (tick)
    );

    assign last_beat = tick && (dur_cnt == DUR_W'(1));
    // The top address acts as an implicit end marker when the song advances past it.
    assign song_end  = ((state == S_LOAD) && (entry_note == NOTE_END)) ||
                       (last_beat && (rom_addr == {ROM_AW{1'b1}}));

    assign busy      = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_PLAY)  || (state == S_PAUSED);
    assign fsm_state = state;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            note_code <= NOTE_REST;
            cur_note  <= NOTE_REST;
            dur_cnt   <= '0;
            song_done <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                rom_addr  <= '0;
                note_code <= NOTE_REST;
            end else if (song_end) begin
                song_done <= 1'b1;
                note_code <= NOTE_REST;
`ifdef SONG_LOOP_EN
                rom_addr  <= '0;
                state     <= S_FETCH;
`else
                state     <= S_DONE;
`endif
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (play) begin
                            rom_addr <= '0;
                            state    <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        cur_note  <= playable(entry_note);
                        note_code <= playable(entry_note);
                        dur_cnt   <= (entry_dur == '0) ? DUR_W'(1) : entry_dur;
                        state     <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (pause) begin
                            note_code <= NOTE_REST;
                            state     <= S_PAUSED;
                        end else if (last_beat) begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end else if (tick) begin
                            dur_cnt <= dur_cnt - 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (play) begin
                            note_code <= cur_note;
                            state     <= S_PLAY;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 4-entry behavioural ROM and hand-computed timings.
module tb_song_sequencer;
    import song_pkg::*;

    localparam int ROM_AW = 2;
    localparam int DUR_W  = 6;
    localparam int DIV_W  = 24;
`ifdef SONG_LOOP_EN
    localparam logic loop_en = 1'b1;
`else
    localparam logic loop_en = 1'b0;
`endif

    logic                    clk50 = 1'b0;
    logic                    reset = 1'b1;
    logic                    play  = 1'b0;
    logic                    pause = 1'b0;
    logic                    stop  = 1'b0;
    logic [DIV_W-1:0]        tick_div = 24'd4;
    logic [ROM_AW-1:0]       rom_addr;
    logic [NOTE_W+DUR_W-1:0] rom_data = '0;
    logic [NOTE_W-1:0]       note_code;
    logic                    busy;
    logic                    song_done;
    state_t                  fsm_state;

    logic [NOTE_W+DUR_W-1:0] rom_mem [4];

    int n_cmp = 0;
    int n_err = 0;
    int len;

    // clock/reset block
    always #10 clk50 = ~clk50;

    always @(posedge clk50) rom_data <= rom_mem[rom_addr];

    song_sequencer #(.ROM_AW(ROM_AW), .DUR_W(DUR_W), .DIV_W(DIV_W)) dut (
        .clk50     (clk50),
        .reset     (reset),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
        .tick_div  (tick_div),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_code (note_code),
        .busy      (busy),
        .song_done (song_done),
        .fsm_state (fsm_state)
    );

    // scoreboard check
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic load_rom(input logic [11:0] e0, input logic [11:0] e1,
                            input logic [11:0] e2, input logic [11:0] e3);
        rom_mem[0] = e0;
        rom_mem[1] = e1;
        rom_mem[2] = e2;
        rom_mem[3] = e3;
    endtask

    task automatic wait_note(input string tag, input logic [5:0] code);
        int n = 0;
        while (note_code !== code && n < 200) begin
            step();
            n++;
        end
        check_eq(tag, 32'(note_code), 32'(code));
    endtask

    task automatic run_len(input logic [5:0] code, output int cycles);
        cycles = 0;
        while (note_code === code && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    function automatic logic [11:0] ent(input logic [5:0] n, input logic [5:0] d);
        return {n, d};
    endfunction

    initial begin
        load_rom(ent(C2, 6'd2), ent(E2, 6'd1), ent(NOTE_END, 6'd0), ent(NOTE_REST, 6'd0));

        // reset values
        step();
        step();
        check_eq("rst_note", 32'(note_code), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(song_done), 32'd0);
        check_eq("rst_addr", 32'(rom_addr), 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'(S_IDLE));
        reset = 1'b0;
        step();

        // basic song: C2 x2 beats, E2 x1 beat, end marker, tick_div=4
        tick_div = 24'd4;
        pulse_play();
        check_eq("fetch_busy", 32'(busy), 32'd1);
        wait_note("c2_start", C2);
        run_len(C2, len);
        check_eq("c2_len", 32'(len), 32'd10);
        run_len(E2, len);
        check_eq("e2_len", 32'(len), 32'd6);
        check_eq("end_note", 32'(note_code), 32'd0);
        check_eq("end_done", 32'(song_done), 32'd1);
        step();
        check_eq("end_done_pulse", 32'(song_done), 32'd0);
        check_eq("end_busy", 32'(busy), 32'(loop_en));
        pulse_stop();

        // pause after 5 C2 cycles, hold 20, resume
        pulse_play();
        wait_note("p_c2_start", C2);
        repeat (5) step();
        check_eq("p_pre_note", 32'(note_code), 32'(C2));
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_eq("p_note", 32'(note_code), 32'd0);
        check_eq("p_state", 32'(fsm_state), 32'(S_PAUSED));
        repeat (20) step();
        check_eq("p_hold_note", 32'(note_code), 32'd0);
        check_eq("p_hold_busy", 32'(busy), 32'd1);
        pulse_play();
        run_len(C2, len);
        check_eq("p_resume_len", 32'(len), 32'd5);
        run_len(E2, len);
        check_eq("p_e2_len", 32'(len), 32'd6);
        pulse_stop();

        // stop and play in the same cycle during PLAY
        pulse_play();
        wait_note("s_c2_start", C2);
        step();
        step();
        stop = 1'b1;
        play = 1'b1;
        step();
        stop = 1'b0;
        play = 1'b0;
        check_eq("s_state", 32'(fsm_state), 32'(S_IDLE));
        check_eq("s_note", 32'(note_code), 32'd0);
        check_eq("s_addr", 32'(rom_addr), 32'd0);
        repeat (3) step();
        check_eq("s_busy", 32'(busy), 32'd0);
        check_eq("s_no_restart", 32'(note_code), 32'd0);

        // dur=0, tick_div=0, invalid note as rest
        tick_div = 24'd0;
        load_rom(ent(E1, 6'd0), ent(6'd40, 6'd2), ent(GS1, 6'd1), ent(NOTE_END, 6'd0));
        pulse_play();
        wait_note("z_e1_start", E1);
        run_len(E1, len);
        check_eq("z_e1_len", 32'(len), 32'd3);
        run_len(NOTE_REST, len);
        check_eq("z_rest_len", 32'(len), 32'd4);
        run_len(GS1, len);
        check_eq("z_gs1_len", 32'(len), 32'd3);
        check_eq("z_done", 32'(song_done), 32'd1);
        pulse_stop();

        // address wrap with no end marker
        tick_div = 24'd1;
        load_rom(ent(C1, 6'd1), ent(CS1, 6'd1), ent(D1, 6'd1), ent(DS1, 6'd1));
        pulse_play();
        wait_note("w_c1_start", C1);
        run_len(C1, len);
        check_eq("w_c1_len", 32'(len), 32'd3);
        run_len(CS1, len);
        check_eq("w_cs1_len", 32'(len), 32'd3);
        run_len(D1, len);
        check_eq("w_d1_len", 32'(len), 32'd3);
        run_len(DS1, len);
        check_eq("w_ds1_len", 32'(len), 32'd1);
        check_eq("w_done", 32'(song_done), 32'd1);
`ifdef SONG_LOOP_EN
        run_len(NOTE_REST, len);
        check_eq("w_loop_gap", 32'(len), 32'd2);
        check_eq("w_loop_note", 32'(note_code), 32'(C1));
        pulse_stop();
`else
        step();
        check_eq("w_state", 32'(fsm_state), 32'(S_DONE));
        check_eq("w_busy", 32'(busy), 32'd0);
        pulse_play();
        wait_note("w_replay", C1);
        pulse_stop();
`endif

        // asynchronous reset during PLAY
        tick_div = 24'd4;
        load_rom(ent(C2, 6'd2), ent(E2, 6'd1), ent(NOTE_END, 6'd0), ent(NOTE_REST, 6'd0));
        pulse_play();
        wait_note("r_c2_start", C2);
        step();
        step();
        #3 reset = 1'b1;
        #1;
        check_eq("r_note", 32'(note_code), 32'd0);
        check_eq("r_busy", 32'(busy), 32'd0);
        check_eq("r_addr", 32'(rom_addr), 32'd0);
        check_eq("r_state", 32'(fsm_state), 32'(S_IDLE));
        step();
        reset = 1'b0;
        step();
        pulse_play();
        wait_note("r_c2_restart", C2);
        run_len(C2, len);
        check_eq("r_c2_len", 32'(len), 32'd10);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a stored song by stepping through a synchronous note ROM.
- Each ROM entry holds a note code and a duration in beat ticks.
- Drives a 6-bit note code into the existing note-to-frequency select (0 = rest, 1..36 = c1..b3), replacing hard-wired per-song case tables with one reusable controller.
- Provides play/pause/stop control, a programmable beat-tick divider, and a song-done pulse.

Parameters:
ROM_AW, 7, ROM address width; song length up to 2^ROM_AW entries
DUR_W, 6, duration field width in ticks
DIV_W, 24, tick divider width

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
play  in  1  single-cycle pulse: start from entry 0 (IDLE/DONE) or resume (PAUSED)
pause  in  1  single-cycle pulse: pause playback (honoured in PLAY only)
stop  in  1  single-cycle pulse: abort, return to IDLE
tick_div  in  DIV_W  clk50 cycles per tick; 0 treated as 1
rom_addr  out  ROM_AW  note ROM address
rom_data  in  6+DUR_W  entry {note[5:0], dur[DUR_W-1:0]}, valid 1 cycle after rom_addr
note_code  out  6  current note to frequency select; 0 = silence
busy  out  1  high in FETCH, LOAD, PLAY, PAUSED
song_done  out  1  one-cycle pulse on end of song

Behaviour:
- Reset values: rom_addr=0, note_code=0, busy=0, song_done=0, state=IDLE, tick counter=0, duration counter=0.
- State machine states: IDLE, FETCH, LOAD, PLAY, PAUSED, DONE.
- Control priority: stop > pause > play.
- stop, from any state: next cycle goes to IDLE; rom_addr=0, note_code=0, tick counter cleared.
- IDLE or DONE + play: rom_addr=0, go to FETCH.
- FETCH: drive rom_addr; one cycle later go to LOAD. note_code holds the previous note, so there is no gap between notes.
- LOAD: decode rom_data.
  - note==6'h3F is the end marker: go to DONE, pulse song_done, note_code=0.
  - note 37..62 is invalid: treated as rest (note_code=0).
  - Otherwise: note_code=note, dur_cnt=max(dur,1), tick counter cleared, go to PLAY.
- Note-to-note spacing: 2 extra cycles of fetch overhead per note, i.e. 2 + dur×tick_div cycles.
- Tick generator:
  - Runs only in PLAY.
  - Counter increments each cycle; when counter >= tick_div-1 it emits a tick and clears.
  - Using >= means a live decrease of tick_div never strands the counter.
- PLAY, on tick:
  - If dur_cnt==1: rom_addr+1, go to FETCH.
  - Else: dur_cnt-1.
- Address wrap: if rom_addr is 2^ROM_AW-1 when advancing, it is an implicit end marker; behaves as end-marker handling (subject to the optional feature).
- PLAY + pause: go to PAUSED.
  - note_code forced to 0.
  - Tick counter and dur_cnt frozen; stored note retained.
- PAUSED + play: return to PLAY with stored note and counters unchanged, so the remaining duration is exact.
- play in FETCH, LOAD or PLAY: ignored. pause outside PLAY: ignored.
- Simultaneous tick-terminal and pause in PLAY: pause wins; the advance is deferred and resumes with dur_cnt=1 and the tick counter at terminal.
- DONE: note_code=0, busy=0; only play or stop leave it.
- Reset asserted mid-song: immediate return to reset values.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: at the end marker or address wrap, song_done still pulses, but the block sets rom_addr=0 and goes to FETCH instead of DONE, so the song repeats until stop.
- Not defined: the block goes to DONE and halts as described above.

Decomposition:
- Shared package song_pkg:
  - Note-code constants NOTE_REST=0, C1=1 .. B3=36, NOTE_END=6'h3F.
  - State enum.
  - Entry field widths.
- One sub-module: song_tick_gen, holding the tick_div counter with enable and clear inputs.

Test Plan:
- ROM {C2,dur2},{E2,dur1},{END}, tick_div=4, play: note_code=13 for 2+8 cycles, then 17, then 0; song_done pulses once; busy falls.
- Mid-C2 pause after 5 cycles, hold 20 cycles, then play: note_code=0 while paused; C2 resumes for exactly the remaining 3 cycles before fetch.
- Same cycle stop+play while in PLAY: IDLE next cycle, note_code=0, rom_addr=0, no restart.
- Entry with dur=0 and tick_div=0: note lasts 1 cycle of tick plus 2 fetch cycles; no hang.
- ROM_AW=2, no end marker, four valid notes: wrap after entry 3 gives song_done, then DONE (without macro) or replay from entry 0 (with SONG_LOOP_EN).
- Reset asserted during PLAY: all outputs 0 asynchronously; play after release starts at entry 0.
